mrsp_reader: RTL

MRSP_READER -- requirements
Module: mrsp_reader

---
 rtl/mrsp_pkg.sv | 19 +
 rtl/mrsp_timeout.sv | 29 ++
 rtl/mrsp_reader.sv | 98 +++++++++
 3 files changed

// File: rtl/mrsp_pkg.sv
// Shared types for the multi-byte register snapshot reader: FSM states,
// byte-select encoding and the byte-pick helper used on the read path.
package mrsp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN_HI = 2'd1,
    OPEN_LO = 2'd2
  } state_e;

  localparam logic A0_HI = 1'b1;
  localparam logic A0_LO = 1'b0;

  // Selected byte zero-extended into the low half of the read bus.
  function automatic logic [15:0] pick_byte(input logic [15:0] word, input logic a0);
    return (a0 == A0_HI) ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
  endfunction

endpackage

// File: rtl/mrsp_timeout.sv
// Saturating 8-bit idle counter; tc_o flags the increment that lands on TIMEOUT.
module mrsp_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [8:0] TC_VAL = 9'(TIMEOUT);

  logic [7:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else if (clr_i) begin
      count_q <= 8'd0;
    end else if (inc_i && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Expiry coincides with the edge that makes the count equal TIMEOUT.
  assign tc_o = inc_i && !clr_i && (({1'b0, count_q} + 9'd1) == TC_VAL);

endmodule

// File: rtl/mrsp_reader.sv
// Coherent two-byte reader: the first byte read snapshots the live 16-bit
// value and the second byte is served from that snapshot.
//
// state   | meaning
// IDLE    | no pair open; next RD snapshots SRC_IN
// OPEN_HI | high byte returned first, low byte pending
// OPEN_LO | low byte returned first, high byte pending
module mrsp_reader
  import mrsp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SRC_IN,
  input  logic        RD,
  input  logic        A0,
  output logic [15:0] D_OUT,
  output logic        RVALID,
  output logic [15:0] SNAP,
  output logic        HALF,
  output logic        STALE
);

  state_e      state_q;
  logic [15:0] snap_q;
  logic [15:0] dout_q;
  logic        rvalid_q;
  logic        stale_q;
  logic        open_w;
  logic        expire_w;

  assign open_w = (state_q != IDLE);

  mrsp_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i(CLK),
    .rst_i(RESET),
    .clr_i(RD),
    .inc_i(open_w && !RD),
    .tc_o (expire_w)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      snap_q   <= 16'h0000;
      dout_q   <= 16'h0000;
      rvalid_q <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      rvalid_q <= RD;
      if (RD) begin
        stale_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (RD) begin
            snap_q  <= SRC_IN;
            dout_q  <= pick_byte(SRC_IN, A0);
            state_q <= (A0 == A0_HI) ? OPEN_HI : OPEN_LO;
          end
        end
        OPEN_HI: begin
          if (RD) begin
            dout_q <= pick_byte(snap_q, A0);
            if (A0 == A0_LO) begin
              state_q <= IDLE;
            end
          end else if (expire_w) begin
            state_q <= IDLE;
            stale_q <= 1'b1;
          end
        end
        OPEN_LO: begin
          if (RD) begin
            dout_q <= pick_byte(snap_q, A0);
            if (A0 == A0_HI) begin
              state_q <= IDLE;
            end
          end else if (expire_w) begin
            state_q <= IDLE;
            stale_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign D_OUT  = dout_q;
  assign RVALID = rvalid_q;
  assign SNAP   = snap_q;
  assign HALF   = open_w;
  assign STALE  = stale_q;

endmodule
